// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the branch target predictor: 2-bit counter
// encodings and the index/tag width derivations from the PC width.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Instructions are word aligned, so the low two PC bits never index the table.
  localparam int unsigned PC_ALIGN_BITS = 2;

  function automatic int unsigned table_depth(input int unsigned index_width);
    return 1 << index_width;
  endfunction

  function automatic int unsigned tag_width(input int unsigned bit_width,
                                            input int unsigned index_width);
    return bit_width - index_width - PC_ALIGN_BITS;
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch/EX-side signal bundle of the branch target predictor.
interface branch_target_predictor_if #(
  parameter int unsigned BIT_WIDTH = 32
);
  logic [BIT_WIDTH-1:0] if_pc;
  logic                 PC_write;
  logic                 IDIF_write;
  logic                 ex_noop;
  logic                 ex_branch;
  logic [BIT_WIDTH-1:0] ex_pc;
  logic [BIT_WIDTH-1:0] ex_target;
  logic                 ex_taken;
  logic                 pred_taken;
  logic [BIT_WIDTH-1:0] pred_target;
  logic                 mispredict;
  logic [BIT_WIDTH-1:0] redirect_pc;

  modport master (
    output if_pc, PC_write, IDIF_write, ex_noop, ex_branch, ex_pc, ex_target, ex_taken,
    input  pred_taken, pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  if_pc, PC_write, IDIF_write, ex_noop, ex_branch, ex_pc, ex_target, ex_taken,
    output pred_taken, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_target_predictor_counter.sv
// Saturating 2-bit branch counter: next value after a resolved outcome.
module branch_prediction_counter
  import bp_pkg::*;
(
  input  ctr_e count,
  input  logic taken,
  output ctr_e next_count
);

  always_comb begin
    next_count = count;
    case (count)
      SNT:     next_count = taken ? WNT : SNT;
      WNT:     next_count = taken ? WT  : SNT;
      WT:      next_count = taken ? ST  : WNT;
      ST:      next_count = taken ? ST  : WT;
      default: next_count = count;
    endcase
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, plus the
// ID/EX prediction pipeline used to detect and redirect mispredictions.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 32,
  parameter int unsigned INDEX_WIDTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  branch_target_predictor_if.slave bus
);

  localparam int unsigned DEPTH   = table_depth(INDEX_WIDTH);
  localparam int unsigned TAG_W   = tag_width(BIT_WIDTH, INDEX_WIDTH);
  localparam int unsigned TAG_LSB = INDEX_WIDTH + PC_ALIGN_BITS;

  typedef logic [INDEX_WIDTH-1:0] idx_t;
  typedef logic [TAG_W-1:0]       tag_t;
  typedef logic [BIT_WIDTH-1:0]   pc_t;

  localparam pc_t PC_STEP = pc_t'(4);

  logic valid_q  [DEPTH];
  tag_t tag_q    [DEPTH];
  pc_t  target_q [DEPTH];
  ctr_e ctr_q    [DEPTH];

  idx_t if_idx, ex_idx;
  tag_t if_tag, ex_tag;
  logic if_hit, ex_hit, lookup_taken;
  ctr_e ex_ctr_next;

  logic id_pred_taken, ex_pred_taken;
  pc_t  id_pred_target, ex_pred_target;
  logic mispredict_raw;

  // The stall only freezes the PC register upstream; lookup and update ignore it.
  logic unused_pc_write;
  assign unused_pc_write = bus.PC_write;

  assign if_idx = bus.if_pc[TAG_LSB-1:PC_ALIGN_BITS];
  assign if_tag = bus.if_pc[BIT_WIDTH-1:TAG_LSB];
  assign ex_idx = bus.ex_pc[TAG_LSB-1:PC_ALIGN_BITS];
  assign ex_tag = bus.ex_pc[BIT_WIDTH-1:TAG_LSB];

  assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign lookup_taken = if_hit && (ctr_q[if_idx] inside {WT, ST});
  assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign bus.pred_taken  = lookup_taken;
  assign bus.pred_target = lookup_taken ? target_q[if_idx] : bus.if_pc + PC_STEP;

  assign mispredict_raw = bus.ex_branch &&
                          ((bus.ex_taken != ex_pred_taken) ||
                           (bus.ex_taken && (bus.ex_target != ex_pred_target)));
  assign bus.mispredict  = rst && mispredict_raw;
  assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_STEP;

  branch_prediction_counter u_counter (
    .count      (ctr_q[ex_idx]),
    .taken      (bus.ex_taken),
    .next_count (ex_ctr_next)
  );

  // A flush wipes both stages regardless of the hazard unit's hold/bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
      ex_pred_taken  <= 1'b0;
      ex_pred_target <= '0;
    end else if (mispredict_raw) begin
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
      ex_pred_taken  <= 1'b0;
      ex_pred_target <= '0;
    end else begin
      if (bus.IDIF_write) begin
        id_pred_taken  <= lookup_taken;
        id_pred_target <= bus.pred_target;
      end
      if (bus.ex_noop) begin
        ex_pred_taken  <= 1'b0;
        ex_pred_target <= '0;
      end else begin
        ex_pred_taken  <= id_pred_taken;
        ex_pred_target <= id_pred_target;
      end
    end
  end

  // Not-taken misses leave the table untouched; taken misses allocate weakly taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (bus.ex_branch) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ex_ctr_next;
        if (bus.ex_taken) begin
          target_q[ex_idx] <= bus.ex_target;
        end
      end else if (bus.ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= bus.ex_target;
        ctr_q[ex_idx]    <= WT;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: directed vector table, hand-written pipeline/reset
// sequences, then randomized traffic against a behavioural model.
module tb_branch_target_predictor;

  localparam int unsigned BW    = 32;
  localparam int unsigned IW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SH    = IW + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  branch_target_predictor_if #(.BIT_WIDTH(BW)) bus ();

  branch_target_predictor #(
    .BIT_WIDTH   (BW),
    .INDEX_WIDTH (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model: table keyed by slot, counters as plain integers 0..3.
  typedef struct {
    bit          valid;
    logic [31:0] tag;
    logic [31:0] target;
    int          ctr;
  } entry_t;

  entry_t      m_tab [DEPTH];
  bit          m_id_t, m_ex_t;
  logic [31:0] m_id_g, m_ex_g;

  function automatic int unsigned slot(input logic [31:0] pc);
    return (pc >> 2) % DEPTH;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_tab[i].valid  = 1'b0;
      m_tab[i].tag    = '0;
      m_tab[i].target = '0;
      m_tab[i].ctr    = 1;
    end
    m_id_t = 0; m_id_g = '0; m_ex_t = 0; m_ex_g = '0;
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output bit t, output logic [31:0] g);
    entry_t e;
    e = m_tab[slot(pc)];
    t = e.valid && (e.tag == (pc >> SH)) && (e.ctr >= 2);
    g = t ? e.target : pc + 32'd4;
  endfunction

  function automatic bit model_misp();
    return rst && bus.ex_branch &&
           ((bus.ex_taken != m_ex_t) || (bus.ex_taken && (bus.ex_target != m_ex_g)));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input bit br, input logic [31:0] epc,
                       input logic [31:0] etg, input bit tk, input bit idif, input bit noop);
    bus.if_pc      = pc;
    bus.ex_branch  = br;
    bus.ex_pc      = epc;
    bus.ex_target  = etg;
    bus.ex_taken   = tk;
    bus.IDIF_write = idif;
    bus.PC_write   = idif;
    bus.ex_noop    = noop;
  endtask

  task automatic settle();
    #2;
    if (!rst) model_reset();
  endtask

  task automatic advance();
    bit          pt, mp, hit;
    logic [31:0] pg;
    int unsigned s;
    if (rst) begin
      model_predict(bus.if_pc, pt, pg);
      mp = model_misp();
      if (mp) begin
        m_ex_t = 0; m_ex_g = '0; m_id_t = 0; m_id_g = '0;
      end else begin
        if (bus.ex_noop) begin m_ex_t = 0; m_ex_g = '0; end
        else begin m_ex_t = m_id_t; m_ex_g = m_id_g; end
        if (bus.IDIF_write) begin m_id_t = pt; m_id_g = pg; end
      end
      if (bus.ex_branch) begin
        s   = slot(bus.ex_pc);
        hit = m_tab[s].valid && (m_tab[s].tag == (bus.ex_pc >> SH));
        if (hit) begin
          if (bus.ex_taken) begin
            m_tab[s].ctr    = (m_tab[s].ctr < 3) ? m_tab[s].ctr + 1 : 3;
            m_tab[s].target = bus.ex_target;
          end else begin
            m_tab[s].ctr = (m_tab[s].ctr > 0) ? m_tab[s].ctr - 1 : 0;
          end
        end else if (bus.ex_taken) begin
          m_tab[s].valid  = 1'b1;
          m_tab[s].tag    = bus.ex_pc >> SH;
          m_tab[s].target = bus.ex_target;
          m_tab[s].ctr    = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pred(input string nm, input bit t, input logic [31:0] g);
    chk({nm, "_taken"},  32'(bus.pred_taken), 32'(t));
    chk({nm, "_target"}, bus.pred_target, g);
  endtask

  // Held in reset for one edge with a would-be mispredict on the EX inputs.
  task automatic reset_dut(input logic [31:0] pc);
    rst = 1'b0;
    drive(pc, 1, 32'h100, 32'h200, 1, 1, 0);
    settle();
    chk_pred("reset_pred", 0, pc + 32'd4);
    chk("reset_misp", 32'(bus.mispredict), 32'd0);
    advance();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] if_pc;
    bit          br;
    logic [31:0] epc;
    logic [31:0] etg;
    bit          tk;
    bit          exp_pt;
    logic [31:0] exp_pg;
    bit          exp_mp;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{32'h100, 0, 32'h000, 32'h000, 0, 0, 32'h104, 0, 32'h004};  // cold start
    vecs[1] = '{32'h100, 1, 32'h100, 32'h200, 1, 0, 32'h104, 1, 32'h200};  // cold miss, allocate
    vecs[2] = '{32'h100, 0, 32'h000, 32'h000, 0, 1, 32'h200, 0, 32'h004};  // now hits
    vecs[3] = '{32'h104, 0, 32'h000, 32'h000, 0, 0, 32'h108, 0, 32'h004};
    vecs[4] = '{32'h100, 1, 32'h100, 32'h200, 1, 1, 32'h200, 0, 32'h200};  // correct prediction
    vecs[5] = '{32'h140, 1, 32'h140, 32'h300, 1, 0, 32'h144, 1, 32'h300};  // alias replaces slot 0
    vecs[6] = '{32'h100, 0, 32'h000, 32'h000, 0, 0, 32'h104, 0, 32'h004};  // old owner misses
    vecs[7] = '{32'h140, 0, 32'h000, 32'h000, 0, 1, 32'h300, 0, 32'h004};

    model_reset();
    reset_dut(32'h100);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].if_pc, vecs[i].br, vecs[i].epc, vecs[i].etg, vecs[i].tk, 1, 0);
      settle();
      chk_pred($sformatf("vec%0d", i), vecs[i].exp_pt, vecs[i].exp_pg);
      chk($sformatf("vec%0d_misp", i), 32'(bus.mispredict), 32'(vecs[i].exp_mp));
      chk($sformatf("vec%0d_redirect", i), bus.redirect_pc, vecs[i].exp_rd);
      advance();
    end

    // Counter saturation at 00 and target rewrite on a taken hit.
    reset_dut(32'h100);
    drive(32'h100, 1, 32'h100, 32'h200, 1, 1, 0); settle(); chk_pred("sat_alloc", 0, 32'h104); advance();
    drive(32'h100, 1, 32'h100, 32'h200, 0, 1, 0); settle(); chk_pred("sat_nt1", 1, 32'h200); advance();
    for (int i = 2; i <= 4; i++) begin
      drive(32'h100, 1, 32'h100, 32'h200, 0, 1, 0); settle();
      chk_pred($sformatf("sat_nt%0d", i), 0, 32'h104); advance();
    end
    drive(32'h100, 1, 32'h100, 32'h240, 1, 1, 0); settle(); chk_pred("sat_up1", 0, 32'h104); advance();
    drive(32'h100, 1, 32'h100, 32'h240, 1, 1, 0); settle(); chk_pred("sat_up2", 0, 32'h104); advance();
    drive(32'h100, 0, 32'h000, 32'h000, 0, 1, 0); settle(); chk_pred("sat_up3", 1, 32'h240); advance();

    // ID hold / EX bubble, then a flush overriding the hold.
    reset_dut(32'h100);
    drive(32'h100, 1, 32'h100, 32'h200, 1, 1, 0); settle(); chk("hold_alloc_misp", 32'(bus.mispredict), 32'd1); advance();
    drive(32'h100, 0, 32'h000, 32'h000, 0, 1, 0); settle(); chk_pred("hold_fetch", 1, 32'h200); advance();
    drive(32'h104, 0, 32'h000, 32'h000, 0, 0, 1); settle(); advance();
    drive(32'h104, 1, 32'h108, 32'h400, 0, 0, 1); settle();
    chk("hold_bubble_misp", 32'(bus.mispredict), 32'd0);
    chk("hold_bubble_redirect", bus.redirect_pc, 32'h10C); advance();
    drive(32'h104, 0, 32'h000, 32'h000, 0, 1, 0); settle(); advance();
    drive(32'h100, 1, 32'h100, 32'h200, 1, 1, 0); settle(); chk("hold_release_misp", 32'(bus.mispredict), 32'd0); advance();
    drive(32'h104, 1, 32'h10C, 32'h500, 1, 0, 0); settle();
    chk("flush_misp", 32'(bus.mispredict), 32'd1);
    chk("flush_redirect", bus.redirect_pc, 32'h500); advance();
    drive(32'h104, 1, 32'h100, 32'h200, 0, 0, 0); settle(); chk("flush_ex_clear", 32'(bus.mispredict), 32'd0); advance();
    drive(32'h104, 1, 32'h100, 32'h200, 0, 0, 0); settle(); chk("flush_id_clear", 32'(bus.mispredict), 32'd0); advance();

    // Mid-run reset pulse: slot 3 held a weakly-taken entry before it.
    reset_dut(32'h10C);
    drive(32'h10C, 0, 32'h000, 32'h000, 0, 1, 0); settle(); chk_pred("post_reset_a", 0, 32'h110); advance();
    drive(32'h100, 0, 32'h000, 32'h000, 0, 1, 0); settle(); chk_pred("post_reset_b", 0, 32'h104); advance();

    // Randomized traffic against the model.
    reset_dut(32'h1000);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc, epc;
      pc  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
          : 32'h1000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      epc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
          : 32'h1000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      drive(pc, $urandom_range(0, 9) < 6, epc, $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2);
      bus.PC_write = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) rst = 1'b0;
      settle();
      begin
        bit          et;
        logic [31:0] eg;
        model_predict(bus.if_pc, et, eg);
        chk("rand_pred", {31'b0, bus.pred_taken} | (bus.pred_target & 32'h0), 32'(et));
        chk("rand_target", bus.pred_target, eg);
        chk("rand_misp", 32'(bus.mispredict), 32'(model_misp()));
        chk("rand_redirect", bus.redirect_pc, bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4);
      end
      advance();
      rst = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
